// File: rtl/fc_vec_loader.sv
// fc_vec_loader: serial-to-parallel front end for one combinational fc neuron.
// Collects IN activation beats into the x vector and holds x stable for SETTLE
// cycles. It then captures the neuron result z and returns it on a
// valid/ready output stream.
module fc_vec_loader #(
  parameter int WIDTH   = 8,
  parameter int IN      = 84,
  parameter int Z_WIDTH = 22,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [WIDTH-1:0]   x [0:IN-1],
  input  logic [Z_WIDTH-1:0] z,
  output logic [Z_WIDTH-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               err_len
);

  localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN - 1);
  localparam logic [3:0]       SET_M1   = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, FILL, SETL, OUT} state_t;

  state_t           state;
  logic             idle_wait;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cnt;
  logic             accept;

  assign accept = s_valid & s_ready;

  // Frame FSM: buffer fill, settle countdown, result capture and output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idle_wait <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      err_len   <= 1'b0;
      for (int i = 0; i < IN; i++) x[i] <= '0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          // Hold off one full cycle after reset release before opening the input.
          idle_wait <= 1'b1;
          if (idle_wait) begin
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end
        FILL: begin
          if (accept) begin
            x[idx] <= s_data;
            if (idx == IDX_LAST) begin
              // Frame is complete even if s_last is missing; flag it but keep the data.
              err_len <= ~s_last;
              idx     <= '0;
              cnt     <= SET_M1;
              s_ready <= 1'b0;
              state   <= SETL;
            end else if (s_last) begin
              // Short frame: drop it and restart from entry 0.
              err_len <= 1'b1;
              idx     <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        SETL: begin
          if (cnt == 4'd0) begin
            m_data  <= z;
            m_valid <= 1'b1;
            state   <= OUT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_vec_loader.sv
// Directed bench for fc_vec_loader with a summing stub standing in for the neuron.
module tb_fc_vec_loader;

  localparam int WIDTH   = 8;
  localparam int IN      = 84;
  localparam int Z_WIDTH = 22;
  localparam int SETTLE  = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [WIDTH-1:0]   s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [WIDTH-1:0]   x [0:IN-1];
  logic [Z_WIDTH-1:0] z;
  logic [Z_WIDTH-1:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic               err_len;

  int errors = 0;
  int checks = 0;

  fc_vec_loader #(.WIDTH(WIDTH), .IN(IN), .Z_WIDTH(Z_WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .x(x), .z(z),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  // Neuron stand-in: z is the plain sum of the x entries
  always_comb begin
    z = '0;
    for (int i = 0; i < IN; i++) z = z + Z_WIDTH'(x[i]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one beat from a negedge and return at the negedge after it is taken.
  // s_valid is left high so consecutive calls stream back-to-back.
  task automatic beat(input logic [WIDTH-1:0] d, input logic l);
    int n;
    n = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("beat_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic count_x_bad(input int base, input int step, output int bad);
    bad = 0;
    for (int i = 0; i < IN; i++)
      if (x[i] !== WIDTH'(base + i * step)) bad++;
  endtask

  int bad;
  int exp_sum;

  initial begin
    rst_n   = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    // 1: reset held for three cycles, then released
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_m_data",  32'(m_data),  32'd0);
    count_x_bad(0, 0, bad);
    check("rst_x_zero", 32'(bad), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_edge1_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("rel_edge2_s_ready", 32'(s_ready), 32'd1);

    // 2: back-to-back frame 0..83, sink always ready
    m_ready = 1'b1;
    for (int i = 0; i < IN; i++) beat(WIDTH'(i), i == IN - 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("f2_s_ready_drop", 32'(s_ready), 32'd0);
    check("f2_m_valid_early", 32'(m_valid), 32'd0);
    count_x_bad(0, 1, bad);
    check("f2_x_ramp", 32'(bad), 32'd0);
    @(negedge clk);
    check("f2_m_valid", 32'(m_valid), 32'd1);
    check("f2_m_data", 32'(m_data), 32'd3486);
    @(negedge clk);
    check("f2_m_valid_clr", 32'(m_valid), 32'd0);
    check("f2_s_ready_back", 32'(s_ready), 32'd1);

    // 3: same frame, sink stalls while the source keeps offering a beat of 99
    m_ready = 1'b0;
    for (int i = 0; i < IN; i++) beat(WIDTH'(i), i == IN - 1);
    s_data = 8'd99;
    s_last = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("f3_hold_m_valid", 32'(m_valid), 32'd1);
      check("f3_hold_m_data", 32'(m_data), 32'd3486);
      check("f3_hold_s_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("f3_release_m_valid", 32'(m_valid), 32'd0);
    check("f3_release_s_ready", 32'(s_ready), 32'd1);
    check("f3_x0_not_consumed", 32'(x[0]), 32'd0);

    // 4: short frame (s_last on beat 40), then a frame of all ones
    for (int i = 0; i <= 40; i++) beat(8'd5, i == 40);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("f4_err_pulse", 32'(err_len), 32'd1);
    @(negedge clk);
    check("f4_err_clear", 32'(err_len), 32'd0);
    check("f4_no_m_valid", 32'(m_valid), 32'd0);
    check("f4_s_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < IN; i++) beat(8'd1, i == IN - 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("f4_ok_no_err", 32'(err_len), 32'd0);
    @(negedge clk);
    check("f4_ones_m_valid", 32'(m_valid), 32'd1);
    check("f4_ones_m_data", 32'(m_data), 32'd84);
    @(negedge clk);

    // 5: full frame with s_last missing on beat 83 and random source gaps
    exp_sum = 0;
    for (int i = 0; i < IN; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      exp_sum += (i % 7) + 10;
      beat(WIDTH'((i % 7) + 10), 1'b0);
    end
    s_valid = 1'b0;
    check("f5_err_pulse", 32'(err_len), 32'd1);
    check("f5_s_ready_drop", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("f5_err_clear", 32'(err_len), 32'd0);
    check("f5_m_valid", 32'(m_valid), 32'd1);
    check("f5_m_data", 32'(m_data), 32'(exp_sum));
    @(negedge clk);

    // 6: reset after beat 50 of a frame, then a fresh frame 1..84
    for (int i = 0; i <= 50; i++) beat(8'd7, 1'b0);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("f6_rst_s_ready", 32'(s_ready), 32'd0);
    check("f6_rst_m_data", 32'(m_data), 32'd0);
    check("f6_rst_z", 32'(z), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("f6_rel_s_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < IN; i++) beat(WIDTH'(i + 1), i == IN - 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    count_x_bad(1, 1, bad);
    check("f6_x_ramp", 32'(bad), 32'd0);
    @(negedge clk);
    check("f6_m_valid", 32'(m_valid), 32'd1);
    check("f6_m_data", 32'(m_data), 32'd3570);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so the run cannot hang
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
